// File: rtl/nts_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// nts_scheduler_pkg
// Shared definitions for the NTS receive scheduler:
//   - state_t            : scheduler FSM encoding (IDLE, SEARCH, XFER)
//   - COUNT_WIDTH        : width of the dispatch/drop statistics counters
//   - MAX_ENGINES        : upper bound on the engine count handled by helpers
//   - nts_capable_mask() : bit i set when engine i can process NTS frames
// -----------------------------------------------------------------------------
package nts_scheduler_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE   = 2'd0,
        STATE_SEARCH = 2'd1,
        STATE_XFER   = 2'd2
    } state_t;

    localparam int COUNT_WIDTH = 32;
    localparam int MAX_ENGINES = 32;

    // Engines 0..engines_nts-1 are NTS-capable; the rest are mini engines.
    function automatic logic [MAX_ENGINES-1:0] nts_capable_mask(input int engines,
                                                                input int engines_nts);
        logic [MAX_ENGINES-1:0] mask;
        mask = '0;
        for (int i = 0; i < MAX_ENGINES; i++) begin
            if (i < engines && i < engines_nts) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/nts_rr_select.sv
// -----------------------------------------------------------------------------
// nts_rr_select
// Purely combinational round-robin selector. Finds the first set bit of elig
// starting at position ptr and wrapping modulo ENGINES.
// Ports:
//   elig   in  ENGINES      eligible engines
//   ptr    in  INDEX_WIDTH  round-robin start position (always < ENGINES)
//   found  out 1            at least one engine is eligible
//   index  out INDEX_WIDTH  selected engine (valid when found)
// -----------------------------------------------------------------------------
module nts_rr_select #(
    parameter int ENGINES     = 4,
    parameter int INDEX_WIDTH = 2
) (
    input  logic [ENGINES-1:0]     elig,
    input  logic [INDEX_WIDTH-1:0] ptr,
    output logic                   found,
    output logic [INDEX_WIDTH-1:0] index
);

    logic [ENGINES-1:0]     rotated;
    logic [INDEX_WIDTH-1:0] offset;
    logic [INDEX_WIDTH:0]   sum;

    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise synthesis infers a latch to hold the old value.
        rotated = '0;
        offset  = '0;

        // rotated[k] is the engine k positions after ptr.
        for (int k = 0; k < ENGINES; k++) begin
            for (int i = 0; i < ENGINES; i++) begin
                if ((int'(ptr) + k) % ENGINES == i) begin
                    rotated[k] = elig[i];
                end
            end
        end

        // Lowest set bit wins: scan downwards so the last write is the lowest.
        for (int k = ENGINES - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = INDEX_WIDTH'(k);
            end
        end

        // Both operands are < ENGINES, so one conditional subtract is a full modulo.
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (INDEX_WIDTH+1)'(ENGINES)) begin
            sum = sum - (INDEX_WIDTH+1)'(ENGINES);
        end

        index = sum[INDEX_WIDTH-1:0];
        found = |elig;
    end

endmodule

// File: rtl/nts_rx_scheduler.sv
// -----------------------------------------------------------------------------
// nts_rx_scheduler
// Assigns each buffered received frame to one eligible NTS engine in
// round-robin order, drops frames no engine accepts within TIMEOUT_CYCLES
// search cycles, and keeps saturating dispatch/drop counters.
// Ports:
//   i_clk, i_areset        clock, asynchronous active-high reset
//   i_frame_valid/_nts     frame pending (level) and its NTS flag
//   o_frame_ack/_drop      one-cycle pulses: frame assigned / dropped
//   i_engine_busy/ready/enable  per-engine status and API enable mask
//   o_grant_valid/_index   transfer in progress and target engine
//   o_grant                one-hot grant, 0 when no transfer
//   i_transfer_done        dispatcher finished streaming to granted engine
//   i_counter_clear        synchronous clear of both counters
//   o_count_dispatched/_dropped  saturating statistics
// All outputs are registered.
// -----------------------------------------------------------------------------
module nts_rx_scheduler
    import nts_scheduler_pkg::*;
#(
    parameter int ENGINES        = 4,
    parameter int ENGINES_NTS    = 2,
    parameter int INDEX_WIDTH    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   i_clk,
    input  logic                   i_areset,
    input  logic                   i_frame_valid,
    input  logic                   i_frame_nts,
    output logic                   o_frame_ack,
    output logic                   o_frame_drop,
    input  logic [ENGINES-1:0]     i_engine_busy,
    input  logic [ENGINES-1:0]     i_engine_ready,
    input  logic [ENGINES-1:0]     i_engine_enable,
    output logic                   o_grant_valid,
    output logic [INDEX_WIDTH-1:0] o_grant_index,
    output logic [ENGINES-1:0]     o_grant,
    input  logic                   i_transfer_done,
    input  logic                   i_counter_clear,
    output logic [COUNT_WIDTH-1:0] o_count_dispatched,
    output logic [COUNT_WIDTH-1:0] o_count_dropped
);

    localparam int                      TCNT_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [TCNT_WIDTH-1:0]   TCNT_LAST  = TCNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [MAX_ENGINES-1:0]  NTS_FULL   = nts_capable_mask(ENGINES, ENGINES_NTS);
    localparam logic [ENGINES-1:0]      NTS_MASK   = NTS_FULL[ENGINES-1:0];
    localparam logic [INDEX_WIDTH-1:0]  LAST_INDEX = INDEX_WIDTH'(ENGINES - 1);

    state_t                 state, state_next;
    logic [INDEX_WIDTH-1:0] ptr, ptr_next;
    logic [TCNT_WIDTH-1:0]  tcnt, tcnt_next;
    logic                   ack_next, drop_next;
    logic                   grant_valid_next;
    logic [INDEX_WIDTH-1:0] grant_index_next;
    logic [ENGINES-1:0]     grant_next;
    logic                   dispatched_inc, dropped_inc;

    logic [ENGINES-1:0]     elig;
    logic                   sel_found;
    logic [INDEX_WIDTH-1:0] sel_index;

    // NTS frames are restricted to NTS-capable engines; others may go anywhere.
    assign elig = i_engine_enable & i_engine_ready & ~i_engine_busy
                & (i_frame_nts ? NTS_MASK : '1);

    nts_rr_select #(
        .ENGINES     (ENGINES),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_rr_select (
        .elig  (elig),
        .ptr   (ptr),
        .found (sel_found),
        .index (sel_index)
    );

    always_comb begin
        state_next       = state;
        ptr_next         = ptr;
        tcnt_next        = tcnt;
        ack_next         = 1'b0;
        drop_next        = 1'b0;
        grant_valid_next = o_grant_valid;
        grant_index_next = o_grant_index;
        grant_next       = o_grant;
        dispatched_inc   = 1'b0;
        dropped_inc      = 1'b0;

        unique case (state)
            STATE_IDLE: begin
                if (i_frame_valid) begin
                    state_next = STATE_SEARCH;
                    tcnt_next  = '0;
                end
            end
            STATE_SEARCH: begin
                if (!i_frame_valid) begin
                    // Frame withdrawn upstream: leave silently, no ack.
                    state_next = STATE_IDLE;
                end else if (sel_found) begin
                    state_next            = STATE_XFER;
                    ack_next              = 1'b1;
                    dispatched_inc        = 1'b1;
                    grant_valid_next      = 1'b1;
                    grant_index_next      = sel_index;
                    grant_next            = '0;
                    grant_next[sel_index] = 1'b1;
                end else if (tcnt == TCNT_LAST) begin
                    state_next  = STATE_IDLE;
                    ack_next    = 1'b1;
                    drop_next   = 1'b1;
                    dropped_inc = 1'b1;
                end else begin
                    tcnt_next = tcnt + 1'b1;
                end
            end
            STATE_XFER: begin
                // Grant is frozen here; engine status changes are ignored.
                if (i_transfer_done) begin
                    state_next       = STATE_IDLE;
                    ptr_next         = (o_grant_index == LAST_INDEX) ? '0
                                                                     : o_grant_index + 1'b1;
                    grant_valid_next = 1'b0;
                    grant_index_next = '0;
                    grant_next       = '0;
                end
            end
            default: begin
                state_next = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state         <= STATE_IDLE;
            ptr           <= '0;
            tcnt          <= '0;
            o_frame_ack   <= 1'b0;
            o_frame_drop  <= 1'b0;
            o_grant_valid <= 1'b0;
            o_grant_index <= '0;
            o_grant       <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state         <= state_next;
            ptr           <= ptr_next;
            tcnt          <= tcnt_next;
            o_frame_ack   <= ack_next;
            o_frame_drop  <= drop_next;
            o_grant_valid <= grant_valid_next;
            o_grant_index <= grant_index_next;
            o_grant       <= grant_next;
        end
    end

    // Clear wins over a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            o_count_dispatched <= '0;
            o_count_dropped    <= '0;
        end else if (i_counter_clear) begin
            o_count_dispatched <= '0;
            o_count_dropped    <= '0;
        end else begin
            if (dispatched_inc && o_count_dispatched != '1) begin
                o_count_dispatched <= o_count_dispatched + 1'b1;
            end
            if (dropped_inc && o_count_dropped != '1) begin
                o_count_dropped <= o_count_dropped + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nts_rx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_nts_rx_scheduler
// Self-checking bench: a behavioural model (integer arithmetic, linear search)
// predicts every registered output each cycle; directed scenarios add literal
// expectations; a randomized phase exercises grants, drops, aborts and clears.
// -----------------------------------------------------------------------------
module tb_nts_rx_scheduler;

    localparam int ENG     = 4;
    localparam int ENG_NTS = 2;
    localparam int IW      = 2;
    localparam int TO      = 12;

    logic           clk;
    logic           rst;
    logic           frame_valid;
    logic           frame_nts;
    logic           frame_ack;
    logic           frame_drop;
    logic [ENG-1:0] busy;
    logic [ENG-1:0] ready;
    logic [ENG-1:0] enable;
    logic           grant_valid;
    logic [IW-1:0]  grant_index;
    logic [ENG-1:0] grant;
    logic           transfer_done;
    logic           counter_clear;
    logic [31:0]    count_dispatched;
    logic [31:0]    count_dropped;

    nts_rx_scheduler #(
        .ENGINES        (ENG),
        .ENGINES_NTS    (ENG_NTS),
        .INDEX_WIDTH    (IW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk              (clk),
        .i_areset           (rst),
        .i_frame_valid      (frame_valid),
        .i_frame_nts        (frame_nts),
        .o_frame_ack        (frame_ack),
        .o_frame_drop       (frame_drop),
        .i_engine_busy      (busy),
        .i_engine_ready     (ready),
        .i_engine_enable    (enable),
        .o_grant_valid      (grant_valid),
        .o_grant_index      (grant_index),
        .o_grant            (grant),
        .i_transfer_done    (transfer_done),
        .i_counter_clear    (counter_clear),
        .o_count_dispatched (count_dispatched),
        .o_count_dropped    (count_dropped)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            if (fails <= 40) begin
                $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, actual, expected);
            end
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for frame, 1 looking for an engine, 2 transferring
    int          m_mode, m_ptr, m_tcnt, m_found;
    bit          e_ack, e_drop, e_gv;
    int          e_idx;
    logic [31:0] e_disp, e_dropc;

    function automatic bit engine_ok(input int j);
        return enable[j] && ready[j] && !busy[j] && (!frame_nts || j < ENG_NTS);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_ptr = 0; m_tcnt = 0;
            e_ack = 0; e_drop = 0; e_gv = 0; e_idx = 0;
            e_disp = 0; e_dropc = 0;
        end else begin
            e_ack  = 0;
            e_drop = 0;
            if (m_mode == 0) begin
                if (frame_valid) begin
                    m_mode = 1;
                    m_tcnt = 0;
                end
            end else if (m_mode == 1) begin
                if (!frame_valid) begin
                    m_mode = 0;
                end else begin
                    m_found = -1;
                    for (int k = 0; k < ENG; k++) begin
                        if (m_found < 0 && engine_ok((m_ptr + k) % ENG)) m_found = (m_ptr + k) % ENG;
                    end
                    if (m_found >= 0) begin
                        e_ack = 1; e_gv = 1; e_idx = m_found; m_mode = 2;
                        if (e_disp != 32'hFFFF_FFFF) e_disp = e_disp + 1;
                    end else if (m_tcnt == TO - 1) begin
                        e_ack = 1; e_drop = 1; m_mode = 0;
                        if (e_dropc != 32'hFFFF_FFFF) e_dropc = e_dropc + 1;
                    end else begin
                        m_tcnt++;
                    end
                end
            end else begin
                if (transfer_done) begin
                    m_ptr = (e_idx + 1) % ENG;
                    e_gv = 0; e_idx = 0; m_mode = 0;
                end
            end
            if (counter_clear) begin
                e_disp  = 0;
                e_dropc = 0;
            end
        end
    end

    function automatic logic [ENG-1:0] onehot(input bit v, input int idx);
        logic [ENG-1:0] g;
        g = '0;
        if (v) g[idx] = 1'b1;
        return g;
    endfunction

    // Compare every cycle on the falling edge, away from the active edge.
    always @(negedge clk) begin
        check("ack",          frame_ack,        e_ack);
        check("drop",         frame_drop,       e_drop);
        check("grant_valid",  grant_valid,      e_gv);
        check("grant_index",  grant_index,      e_idx);
        check("grant_onehot", grant,            onehot(e_gv, e_idx));
        check("count_disp",   count_dispatched, e_disp);
        check("count_drop",   count_dropped,    e_dropc);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        frame_valid   = 0;
        frame_nts     = 0;
        busy          = '0;
        ready         = '1;
        enable        = '1;
        transfer_done = 0;
        counter_clear = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    // Wait (bounded) for an ack; latency counted from the cycle valid was set.
    task automatic wait_ack(input int max_wait, output int lat, output bit dropped,
                            output int idx, output logic [ENG-1:0] g);
        int  t0;
        bit  got;
        t0 = cyc; got = 0; lat = -1; dropped = 0; idx = -1; g = '0;
        for (int n = 0; n < max_wait && !got; n++) begin
            tick();
            if (frame_ack) begin
                got = 1; lat = cyc - t0; dropped = frame_drop;
                idx = int'(grant_index); g = grant;
            end
        end
        if (!got) check("ack_wait_expired", 0, 1);
    endtask

    task automatic pulse_done(input int wait_cycles);
        repeat (wait_cycles) tick();
        transfer_done = 1;
        tick();
        transfer_done = 0;
    endtask

    int             lat, idx;
    bit             dropped, seen;
    logic [ENG-1:0] g;
    int             exp_wrap [5] = '{0, 1, 2, 3, 0};

    initial begin
        rst = 0;
        idle_inputs();
        #1;
        do_reset();
        check("reset_grant_valid", grant_valid, 0);
        check("reset_grant",       grant, 0);
        check("reset_counts",      {count_dispatched, count_dropped}, 0);

        // Basic grant: index 0 two cycles after valid, then index 1.
        frame_valid = 1;
        wait_ack(10, lat, dropped, idx, g);
        frame_valid = 0;
        check("basic_latency", lat, 2);
        check("basic_index", idx, 0);
        check("basic_onehot", g, 4'b0001);
        check("basic_not_dropped", dropped, 0);
        pulse_done(3);
        check("basic_grant_released", grant_valid, 0);
        frame_valid = 1;
        wait_ack(10, lat, dropped, idx, g);
        frame_valid = 0;
        check("basic_second_index", idx, 1);
        pulse_done(1);

        // Wrap-around: five back-to-back frames, valid held throughout.
        do_reset();
        frame_valid = 1;
        for (int f = 0; f < 5; f++) begin
            wait_ack(10, lat, dropped, idx, g);
            check("wrap_index", idx, exp_wrap[f]);
            check("wrap_latency", lat, 2);
            pulse_done(0);
        end
        frame_valid = 0;
        tick();
        check("wrap_count", count_dispatched, 5);

        // NTS restriction: only mini engines free, engine 1 freed later.
        do_reset();
        busy = 4'b0011;
        frame_nts = 1;
        frame_valid = 1;
        seen = 0;
        for (int n = 1; n <= 9; n++) begin
            tick();
            if (frame_ack || grant_valid) seen = 1;
        end
        check("nts_no_early_grant", seen, 0);
        busy = 4'b0001;
        tick();
        check("nts_ack_at_10", frame_ack, 1);
        check("nts_index", grant_index, 1);
        frame_valid = 0;
        frame_nts = 0;
        pulse_done(1);

        // Timeout: nothing enabled, drop after TO+1 cycles.
        do_reset();
        enable = '0;
        frame_valid = 1;
        wait_ack(TO + 10, lat, dropped, idx, g);
        frame_valid = 0;
        check("timeout_latency", lat, 13);
        check("timeout_dropped", dropped, 1);
        check("timeout_grant_zero", g, 0);
        tick();
        check("timeout_drop_count", count_dropped, 1);
        check("timeout_disp_count", count_dispatched, 0);

        // Abort: valid withdrawn during search gives no ack.
        do_reset();
        enable = '0;
        frame_valid = 1;
        repeat (3) tick();
        frame_valid = 0;
        seen = 0;
        for (int n = 0; n < TO + 4; n++) begin
            tick();
            if (frame_ack) seen = 1;
        end
        check("abort_no_ack", seen, 0);
        check("abort_no_drop_count", count_dropped, 0);
        enable = '1;
        frame_valid = 1;
        wait_ack(10, lat, dropped, idx, g);
        frame_valid = 0;
        check("abort_then_latency", lat, 2);
        pulse_done(0);

        // Clear coincident with a grant.
        do_reset();
        frame_valid = 1;
        tick();
        counter_clear = 1;
        tick();
        counter_clear = 0;
        frame_valid = 0;
        check("clear_ack", frame_ack, 1);
        check("clear_wins", count_dispatched, 0);
        pulse_done(0);

        // Reset in the middle of a transfer.
        do_reset();
        frame_valid = 1;
        wait_ack(10, lat, dropped, idx, g);
        pulse_done(0);
        wait_ack(10, lat, dropped, idx, g);
        frame_valid = 0;
        check("rst_pre_index", idx, 1);
        tick();
        #1 rst = 1;
        #1;
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant", grant, 0);
        check("rst_ack", frame_ack, 0);
        check("rst_count", count_dispatched, 0);
        tick();
        rst = 0;
        frame_valid = 1;
        wait_ack(10, lat, dropped, idx, g);
        frame_valid = 0;
        check("rst_next_index", idx, 0);
        pulse_done(0);

        // Randomized traffic, checked cycle by cycle against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (frame_ack) begin
                frame_valid = ($urandom_range(0, 3) == 0);
                frame_nts   = 1'($urandom_range(0, 1));
            end else if (!frame_valid) begin
                if ($urandom_range(0, 2) == 0) begin
                    frame_valid = 1;
                    frame_nts   = 1'($urandom_range(0, 1));
                end
            end else if ($urandom_range(0, 63) == 0) begin
                frame_valid = 0;
            end
            busy          = 4'($urandom_range(0, 15));
            ready         = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
            enable        = ((c / 400) % 3 == 2) ? 4'b0000
                                                 : (4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15)));
            transfer_done = ($urandom_range(0, 3) == 0);
            counter_clear = ($urandom_range(0, 127) == 0);
        end
        idle_inputs();
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
